// File: rtl/nibble_serial_alu_ctrl.sv
// nibble_serial_alu_ctrl: WIDTH-bit add/subtract sequenced one nibble per
// clock through a single 74LS283-style 4-bit adder, LSB nibble first.
// Optional feature macro: NIBBLE_ALU_OVF_EN (signed overflow flag on o_ovf;
// when undefined o_ovf is tied low).

// 4-bit binary full adder with fast carry, behavioural model of the 74LS283.
module dm74ls283_quad_adder (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_cin,
    output logic [3:0] o_sum,
    output logic       o_cout
);
    logic [4:0] w_full;

    assign w_full = {1'b0, i_a} + {1'b0, i_b} + {4'b0000, i_cin};
    assign o_sum  = w_full[3:0];
    assign o_cout = w_full[4];
endmodule

module nibble_serial_alu_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_sub,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_result,
    output logic             o_carry,
    output logic             o_zero,
    output logic             o_ovf
);
    localparam int NIB  = WIDTH / 4;
    localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIB - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_accept;
    logic             w_last;

    logic [WIDTH-1:0] r_opa;
    logic [WIDTH-1:0] r_opb;
    logic             r_c;
    logic [IDXW-1:0]  r_idx;
    logic [WIDTH-1:0] r_result;
    logic             r_carry;
    logic             r_zero;

    logic [3:0]       w_nib_a;
    logic [3:0]       w_nib_b;
    logic [3:0]       w_sum;
    logic             w_cout;
    logic [WIDTH-1:0] w_res_nxt;

    // Nibble select feeding the single adder chip.
    assign w_nib_a = r_opa[{r_idx, 2'b00} +: 4];
    assign w_nib_b = r_opb[{r_idx, 2'b00} +: 4];

    dm74ls283_quad_adder u_adder (
        .i_a    (w_nib_a),
        .i_b    (w_nib_b),
        .i_cin  (r_c),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    // Result as it will look after this cycle's nibble write; used for zero/ovf
    // so the flags see the final nibble on the DONE-entry edge.
    always_comb begin
        w_res_nxt = r_result;
        w_res_nxt[{r_idx, 2'b00} +: 4] = w_sum;
    end

    // Next-state logic; a start is accepted in IDLE or DONE, never in RUN.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                w_last = (r_idx == LAST_IDX);
                if (w_last) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                if (i_start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_RUN;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Operand capture, per-nibble result write and flag update at DONE entry.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_opa    <= '0;
            r_opb    <= '0;
            r_c      <= 1'b0;
            r_idx    <= '0;
            r_result <= '0;
            r_carry  <= 1'b0;
            r_zero   <= 1'b0;
        end else if (w_accept) begin
            // Subtract is A + ~B + 1: invert B here and seed the carry with 1.
            r_opa    <= i_a;
            r_opb    <= i_sub ? ~i_b : i_b;
            r_c      <= i_sub;
            r_idx    <= '0;
            r_result <= '0;
        end else if (r_state == S_RUN) begin
            r_result <= w_res_nxt;
            r_c      <= w_cout;
            r_idx    <= r_idx + IDXW'(1);
            if (w_last) begin
                r_carry <= w_cout;
                r_zero  <= (w_res_nxt == '0);
            end
        end
    end

`ifdef NIBBLE_ALU_OVF_EN
    logic r_ovf;
    logic w_ovf_nxt;

    // Same-sign operands (B after inversion) giving an opposite-sign result.
    assign w_ovf_nxt = (r_opa[WIDTH-1] == r_opb[WIDTH-1]) &&
                       (w_res_nxt[WIDTH-1] != r_opa[WIDTH-1]);

    // Overflow flag, updated only on the DONE-entry edge.
    always_ff @(posedge i_clk) begin
        if (i_rst)                            r_ovf <= 1'b0;
        else if ((r_state == S_RUN) && w_last) r_ovf <= w_ovf_nxt;
    end

    assign o_ovf = r_ovf;
`else
    assign o_ovf = 1'b0;
`endif

    assign o_busy   = (r_state == S_RUN);
    assign o_done   = (r_state == S_DONE);
    assign o_result = r_result;
    assign o_carry  = r_carry;
    assign o_zero   = r_zero;
endmodule
